// File: rtl/omem_scheduler.sv
// rtl/omem_scheduler.sv - round-robin output-memory arbiter, timestep sequencer and end-of-timestep broadcaster (optional OMEM_SCHED_PERF_EN conflict counter)
module omem_scheduler #(
    parameter int NUM_SPE     = 5,
    parameter int OUTPUT_SIZE = 21,
    parameter int NUM_PE      = 11,
    parameter int NUM_TS      = 2,
    parameter int ADDR_W      = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_SPE-1:0] req_valid,
    input  logic [NUM_SPE-1:0] req_write,
    output logic [NUM_SPE-1:0] grant,
    output logic               mem_en,
    output logic               mem_we,
    output logic               mem_bank,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               rsp_valid,
    output logic [2:0]         rsp_spe,
    output logic               bc_valid,
    output logic [3:0]         bc_dest,
    input  logic               bc_ready,
    output logic [1:0]         ts,
    output logic               done
`ifdef OMEM_SCHED_PERF_EN
    ,
    output logic [15:0]        conflict_cnt
`endif
);

    localparam int TS_ENTRIES = OUTPUT_SIZE * OUTPUT_SIZE;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_BCAST = 2'd2;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  ptr [NUM_SPE];
    logic [8:0]         wr_cnt;
    logic [2:0]         last;
    logic [3:0]         dest;
    logic [NUM_SPE-1:0] elig;
    logic               gvalid;
    logic               gwrite;
    logic [2:0]         gidx;
    logic [1:0]         ts_m1;

    // A write is held off once its SPE has run past the end of the map; reads never are.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SPE; i++) begin
            elig[i] = (state == S_SERVE) && req_valid[i] &&
                      (!req_write[i] || (ptr[i] < ADDR_W'(TS_ENTRIES)));
        end
    end

    // Walk from farthest to nearest so the first eligible index after last wins.
    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        for (int k = NUM_SPE; k >= 1; k--) begin
            if (elig[(int'(last) + k) % NUM_SPE]) begin
                gvalid = 1'b1;
                gidx   = 3'((int'(last) + k) % NUM_SPE);
            end
        end
    end

    assign gwrite   = gvalid && req_write[gidx];
    assign ts_m1    = ts - 2'd1;
    assign grant    = gvalid ? (NUM_SPE'(1) << gidx) : '0;
    assign mem_en   = gvalid;
    assign mem_we   = gwrite;
    assign mem_bank = gwrite ? ts_m1[0] : 1'b0;
    assign mem_addr = gvalid ? ptr[gidx] : '0;
    assign bc_valid = (state == S_BCAST);
    assign bc_dest  = dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ts        <= '0;
            wr_cnt    <= '0;
            last      <= 3'(NUM_SPE - 1);
            dest      <= '0;
            rsp_valid <= 1'b0;
            rsp_spe   <= '0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_SPE; i++) ptr[i] <= ADDR_W'(i);
        end else begin
            done      <= 1'b0;
            rsp_valid <= gvalid && !gwrite;
            rsp_spe   <= (gvalid && !gwrite) ? gidx : 3'd0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_SERVE;
                        ts     <= 2'd1;
                        wr_cnt <= '0;
                        for (int i = 0; i < NUM_SPE; i++) ptr[i] <= ADDR_W'(i);
                    end
                end
                S_SERVE: begin
                    if (gvalid) begin
                        last <= gidx;
                        if (gwrite) begin
                            ptr[gidx] <= ptr[gidx] + ADDR_W'(NUM_SPE);
                            if (wr_cnt != 9'(TS_ENTRIES)) wr_cnt <= wr_cnt + 9'd1;
                            if (wr_cnt == 9'(TS_ENTRIES - 1)) begin
                                state <= S_BCAST;
                                dest  <= '0;
                            end
                        end
                    end
                end
                S_BCAST: begin
                    if (bc_ready) begin
                        if (dest == 4'(NUM_PE - 1)) begin
                            dest   <= '0;
                            wr_cnt <= '0;
                            for (int i = 0; i < NUM_SPE; i++) ptr[i] <= ADDR_W'(i);
                            if (ts == 2'(NUM_TS)) begin
                                ts    <= '0;
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end else begin
                                ts    <= ts + 2'd1;
                                state <= S_SERVE;
                            end
                        end else begin
                            dest <= dest + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef OMEM_SCHED_PERF_EN
    // Counts SERVE cycles where the arbiter had to turn at least one eligible request away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            conflict_cnt <= '0;
        end else if ((elig & (elig - NUM_SPE'(1))) != '0 && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_omem_scheduler.sv
// tb/tb_omem_scheduler.sv - vector table, directed sequences and random run against a reference model
module tb_omem_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] req_valid = '0;
    logic [4:0] req_write = '0;
    logic       bc_ready = 1'b0;
    logic [4:0] grant;
    logic       mem_en, mem_we, mem_bank, rsp_valid, bc_valid, done;
    logic [8:0] mem_addr;
    logic [2:0] rsp_spe;
    logic [3:0] bc_dest;
    logic [1:0] ts;
`ifdef OMEM_SCHED_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    omem_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req_valid(req_valid), .req_write(req_write),
        .grant(grant), .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank),
        .mem_addr(mem_addr), .rsp_valid(rsp_valid), .rsp_spe(rsp_spe),
        .bc_valid(bc_valid), .bc_dest(bc_dest), .bc_ready(bc_ready),
        .ts(ts), .done(done)
`ifdef OMEM_SCHED_PERF_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 serving, 2 broadcasting.
    int m_mode, m_ts, m_cnt, m_last, m_dest, m_rsp_v, m_rsp_spe, m_done, m_conf;
    int m_ptr [5];

    function automatic int model_pick();
        for (int k = 1; k <= 5; k++) begin
            int idx;
            idx = (m_last + k) % 5;
            if (m_mode == 1 && req_valid[idx] && (!req_write[idx] || m_ptr[idx] < 441)) return idx;
        end
        return -1;
    endfunction

    function automatic int model_eligible_count();
        int n;
        n = 0;
        for (int i = 0; i < 5; i++)
            if (m_mode == 1 && req_valid[i] && (!req_write[i] || m_ptr[i] < 441)) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ts = 0; m_cnt = 0; m_last = 4; m_dest = 0;
        m_rsp_v = 0; m_rsp_spe = 0; m_done = 0; m_conf = 0;
        for (int i = 0; i < 5; i++) m_ptr[i] = i;
    endtask

    task automatic model_clock();
        int g, n;
        g = model_pick();
        n = model_eligible_count();
        m_done = 0;
        m_rsp_v = (g >= 0 && !req_write[g]) ? 1 : 0;
        m_rsp_spe = m_rsp_v ? g : 0;
        if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_ts = 1; m_cnt = 0; m_conf = 0;
                for (int i = 0; i < 5; i++) m_ptr[i] = i;
            end
        end else if (m_mode == 1) begin
            if (n > 1 && m_conf < 65535) m_conf++;
            if (g >= 0) begin
                m_last = g;
                if (req_write[g]) begin
                    m_ptr[g] += 5;
                    m_cnt++;
                    if (m_cnt == 441) begin m_mode = 2; m_dest = 0; end
                end
            end
        end else if (bc_ready) begin
            if (m_dest == 10) begin
                m_dest = 0; m_cnt = 0;
                for (int i = 0; i < 5; i++) m_ptr[i] = i;
                if (m_ts == 2) begin m_ts = 0; m_mode = 0; m_done = 1; end
                else begin m_ts++; m_mode = 1; end
            end else begin
                m_dest++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, got, exp);
        end
    endtask

    task automatic check_model();
        int g;
        #1;
        g = model_pick();
        chk("grant", grant, g >= 0 ? (1 << g) : 0);
        chk("mem_en", mem_en, g >= 0);
        chk("mem_we", mem_we, g >= 0 && req_write[g]);
        chk("mem_bank", mem_bank, (g >= 0 && req_write[g] && m_ts == 2));
        chk("mem_addr", mem_addr, g >= 0 ? m_ptr[g] : 0);
        chk("rsp_valid", rsp_valid, m_rsp_v);
        chk("rsp_spe", rsp_spe, m_rsp_spe);
        chk("bc_valid", bc_valid, m_mode == 2);
        chk("bc_dest", bc_dest, m_dest);
        chk("ts", ts, m_ts);
        chk("done", done, m_done);
`ifdef OMEM_SCHED_PERF_EN
        chk("conflict_cnt", conflict_cnt, m_conf);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        cycle++;
    endtask

    task automatic check_all_zero();
        chk("rst_grant", grant, 0);     chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);   chk("rst_mem_bank", mem_bank, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_spe", rsp_spe, 0); chk("rst_bc_valid", bc_valid, 0);
        chk("rst_bc_dest", bc_dest, 0); chk("rst_ts", ts, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 0; req_valid = '0; req_write = '0; bc_ready = 0;
        #1;
        check_all_zero();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       start;
        logic [4:0] rv;
        logic [4:0] rw;
        logic [4:0] grant;
        logic       we;
        logic [8:0] addr;
        logic       rsp_v;
        logic [2:0] rsp_spe;
        logic [1:0] ts;
    } vec_t;

    vec_t tbl [8];
    int   bc_cycles;
    bit   seen_done;

    initial begin
        tbl[0] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b0, 9'd0, 1'b0, 3'd0, 2'd0};
        tbl[1] = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0, 9'd0, 1'b0, 3'd0, 2'd0};
        tbl[2] = '{1'b0, 5'b11111, 5'b11111, 5'b00001, 1'b1, 9'd0, 1'b0, 3'd0, 2'd1};
        tbl[3] = '{1'b0, 5'b11111, 5'b11111, 5'b00010, 1'b1, 9'd1, 1'b0, 3'd0, 2'd1};
        tbl[4] = '{1'b0, 5'b00100, 5'b00000, 5'b00100, 1'b0, 9'd2, 1'b0, 3'd0, 2'd1};
        tbl[5] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0, 9'd0, 1'b1, 3'd2, 2'd1};
        tbl[6] = '{1'b0, 5'b10001, 5'b11111, 5'b10000, 1'b1, 9'd4, 1'b0, 3'd0, 2'd1};
        tbl[7] = '{1'b0, 5'b10001, 5'b10001, 5'b00001, 1'b1, 9'd5, 1'b0, 3'd0, 2'd1};

        @(negedge clk);
        apply_reset();

        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start; req_valid = tbl[i].rv; req_write = tbl[i].rw;
            #1;
            chk("tbl_grant", grant, tbl[i].grant);
            chk("tbl_mem_en", mem_en, tbl[i].grant != 0);
            chk("tbl_mem_we", mem_we, tbl[i].we);
            chk("tbl_mem_bank", mem_bank, 0);
            chk("tbl_mem_addr", mem_addr, tbl[i].addr);
            chk("tbl_rsp_valid", rsp_valid, tbl[i].rsp_v);
            chk("tbl_rsp_spe", rsp_spe, tbl[i].rsp_spe);
            chk("tbl_ts", ts, tbl[i].ts);
            advance();
        end
        start = 0;

        // SPE2 write moves ptr[2] to 7, then a read at 7 must leave it there.
        req_valid = 5'b00100; req_write = 5'b00100; check_model(); advance();
        req_write = 5'b00000; check_model();
        chk("rd_addr", mem_addr, 7); chk("rd_we", mem_we, 0); chk("rd_bank", mem_bank, 0);
        advance();
        req_valid = 5'b00100; req_write = 5'b00100; check_model();
        chk("rsp_valid_after_read", rsp_valid, 1); chk("rsp_spe_after_read", rsp_spe, 2);
        chk("ptr2_kept", mem_addr, 7);
        advance();

        // Continuous writes to completion with bc_ready low 3 of every 4 broadcast cycles.
        bc_cycles = 0; seen_done = 0;
        for (int c = 0; c < 6000 && !seen_done; c++) begin
            req_valid = 5'b11111; req_write = 5'b11111;
            bc_ready = (m_mode == 2) && (bc_cycles % 4 == 3);
            check_model();
            if (m_mode == 2) bc_cycles++;
            if (done === 1'b1) seen_done = 1;
            advance();
        end
        chk("run1_done_seen", seen_done, 1);
        for (int c = 0; c < 3; c++) begin
            check_model();
            chk("idle_no_grant", grant, 0);
            chk("idle_ts", ts, 0);
            advance();
        end

        // Random traffic, including start pulses that land outside IDLE.
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom_range(0, 15) == 0);
            req_valid = 5'($urandom);
            req_write = ~(5'($urandom) & 5'($urandom));
            bc_ready  = ($urandom_range(0, 2) != 0);
            check_model();
            advance();
        end
        start = 0;

        // Reset while broadcasting to PE 6; nothing may resume afterwards.
        apply_reset();
        start = 1; check_model(); advance(); start = 0;
        for (int c = 0; c < 2000; c++) begin
            req_valid = 5'b11111; req_write = 5'b11111; bc_ready = (m_mode == 2);
            check_model();
            if (m_mode == 2 && m_dest == 6) break;
            advance();
        end
        chk("reached_dest6", bc_dest, 6);
        apply_reset();
        req_valid = 5'b11111; req_write = 5'b11111;
        check_model(); chk("post_rst_idle_grant", grant, 0);
        start = 1; advance(); start = 0;
        check_model();
        chk("restart_ts", ts, 1); chk("restart_bc", bc_valid, 0);
        chk("restart_grant", grant, 5'b00001); chk("restart_addr", mem_addr, 0);
        advance();

`ifdef OMEM_SCHED_PERF_EN
        apply_reset();
        start = 1; check_model(); advance(); start = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 5'b11111; req_write = 5'b11111; check_model(); advance();
        end
        chk("conflict_ten", conflict_cnt, 10);
        for (int c = 0; c < 4; c++) begin
            req_valid = 5'b01000; req_write = 5'b01000; check_model(); advance();
        end
        chk("conflict_single", conflict_cnt, 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
